// File: rtl/blob_bbox_tracker_pkg.sv
// blob_bbox_tracker_pkg: shared FSM encoding, default widths and table entry layout.
// Entry width grows when BBOX_AREA_EN adds the per-label pixel count.
package blob_bbox_tracker_pkg;
    localparam int WORD_SIZE   = 8;
    localparam int COORD_W_DEF = 11;
    localparam logic [2:0] ST_ACCUM = 3'd0;
    localparam logic [2:0] ST_FLUSH = 3'd1;
    localparam logic [2:0] ST_DUMP  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_CLEAR = 3'd4;
    // Entry slots in units of COORD_W: {area?, valid, xmin, xmax, ymin, ymax}
    localparam int F_YMAX  = 0;
    localparam int F_YMIN  = 1;
    localparam int F_XMAX  = 2;
    localparam int F_XMIN  = 3;
    localparam int F_VALID = 4;
    function automatic int entry_w(input int cw);
`ifdef BBOX_AREA_EN
        return 6 * cw + 1;
`else
        return 4 * cw + 1;
`endif
    endfunction
endpackage

// File: rtl/blob_bbox_tracker_merge.sv
// bbox_merge: folds one pixel coordinate into a bounding-box entry.
// Under BBOX_AREA_EN also advances a saturating pixel count.
module bbox_merge
    import blob_bbox_tracker_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic                 in_valid,
    input  logic [COORD_W-1:0]   in_xmin,
    input  logic [COORD_W-1:0]   in_xmax,
    input  logic [COORD_W-1:0]   in_ymin,
    input  logic [COORD_W-1:0]   in_ymax,
`ifdef BBOX_AREA_EN
    input  logic [2*COORD_W-1:0] in_area,
    output logic [2*COORD_W-1:0] out_area,
`endif
    input  logic [COORD_W-1:0]   px,
    input  logic [COORD_W-1:0]   py,
    output logic [COORD_W-1:0]   out_xmin,
    output logic [COORD_W-1:0]   out_xmax,
    output logic [COORD_W-1:0]   out_ymin,
    output logic [COORD_W-1:0]   out_ymax
);
`ifdef BBOX_AREA_EN
    localparam logic [2*COORD_W-1:0] AREA_ONE = {{(2*COORD_W-1){1'b0}}, 1'b1};
`endif
    always_comb begin
        out_xmin = (!in_valid || px < in_xmin) ? px : in_xmin;
        out_xmax = (!in_valid || px > in_xmax) ? px : in_xmax;
        out_ymin = (!in_valid || py < in_ymin) ? py : in_ymin;
        out_ymax = (!in_valid || py > in_ymax) ? py : in_ymax;
`ifdef BBOX_AREA_EN
        out_area = !in_valid ? AREA_ONE : (&in_area ? in_area : in_area + AREA_ONE);
`endif
    end
endmodule

// File: rtl/blob_bbox_tracker.sv
// blob_bbox_tracker: per-label bounding boxes over a frame, drained on frame_end.
// Optional BBOX_AREA_EN adds a saturating pixel count and the out_area port.
module blob_bbox_tracker
    import blob_bbox_tracker_pkg::*;
#(
    parameter int LABEL_W = WORD_SIZE,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [31:0]          x,
    input  logic [31:0]          y,
    input  logic [LABEL_W-1:0]   label,
    input  logic                 frame_end,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LABEL_W-1:0]   out_label,
    output logic [COORD_W-1:0]   out_xmin,
    output logic [COORD_W-1:0]   out_xmax,
    output logic [COORD_W-1:0]   out_ymin,
    output logic [COORD_W-1:0]   out_ymax,
`ifdef BBOX_AREA_EN
    output logic [2*COORD_W-1:0] out_area,
`endif
    output logic                 busy,
    output logic                 dropped
);
    localparam int EW    = entry_w(COORD_W);
    localparam int DEPTH = 1 << LABEL_W;
    localparam int VB    = F_VALID * COORD_W;

    logic [2:0]         state_q, state_d;
    logic               flush_cnt_q, flush_cnt_d;
    logic [LABEL_W-1:0] idx_q, idx_d;
    logic               s1_valid_q, s1_valid_d;
    logic [LABEL_W-1:0] s1_label_q, s1_label_d;
    logic [COORD_W-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic               s2_valid_q, s2_valid_d;
    logic [LABEL_W-1:0] s2_label_q, s2_label_d;
    logic [EW-1:0]      s2_entry_q, s2_entry_d;
    logic               out_valid_q, out_valid_d;
    logic [LABEL_W-1:0] out_label_q, out_label_d;
    logic [COORD_W-1:0] out_xmin_q, out_xmin_d, out_xmax_q, out_xmax_d;
    logic [COORD_W-1:0] out_ymin_q, out_ymin_d, out_ymax_q, out_ymax_d;
    logic               dropped_q, dropped_d;

    logic [EW-1:0]      mem [DEPTH];
    logic [EW-1:0]      rd_q, src, merged, wd;
    logic [LABEL_W-1:0] rd_addr, wa;
    logic               we, fwd;
    logic [COORD_W-1:0] m_xmin, m_xmax, m_ymin, m_ymax;
    logic               unused_hi;

    assign unused_hi = ^{x[31:COORD_W], y[31:COORD_W]};

    // A write from the previous cycle may have raced the read; take the S2 copy instead.
    assign fwd     = s2_valid_q && (s2_label_q == s1_label_q);
    assign src     = fwd ? s2_entry_q : rd_q;
    assign rd_addr = (state_q == ST_ACCUM) ? label : idx_d;

`ifdef BBOX_AREA_EN
    logic [2*COORD_W-1:0] m_area, out_area_q, out_area_d;
    assign out_area = out_area_q;
`endif

    bbox_merge #(.COORD_W(COORD_W)) u_merge (
        .in_valid (src[VB]),
        .in_xmin  (src[F_XMIN*COORD_W +: COORD_W]),
        .in_xmax  (src[F_XMAX*COORD_W +: COORD_W]),
        .in_ymin  (src[F_YMIN*COORD_W +: COORD_W]),
        .in_ymax  (src[F_YMAX*COORD_W +: COORD_W]),
`ifdef BBOX_AREA_EN
        .in_area  (src[VB+1 +: 2*COORD_W]),
        .out_area (m_area),
`endif
        .px       (s1_x_q),
        .py       (s1_y_q),
        .out_xmin (m_xmin),
        .out_xmax (m_xmax),
        .out_ymin (m_ymin),
        .out_ymax (m_ymax)
    );

    always_comb begin
        merged = '0;
        merged[F_XMIN*COORD_W +: COORD_W] = m_xmin;
        merged[F_XMAX*COORD_W +: COORD_W] = m_xmax;
        merged[F_YMIN*COORD_W +: COORD_W] = m_ymin;
        merged[F_YMAX*COORD_W +: COORD_W] = m_ymax;
        merged[VB] = 1'b1;
`ifdef BBOX_AREA_EN
        merged[VB+1 +: 2*COORD_W] = m_area;
`endif
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        idx_d       = idx_q;
        s1_valid_d  = en && (label != '0) && (state_q == ST_ACCUM);
        s1_label_d  = label;
        s1_x_d      = x[COORD_W-1:0];
        s1_y_d      = y[COORD_W-1:0];
        s2_valid_d  = s1_valid_q;
        s2_label_d  = s1_label_q;
        s2_entry_d  = merged;
        out_valid_d = out_valid_q;
        out_label_d = out_label_q;
        out_xmin_d  = out_xmin_q;
        out_xmax_d  = out_xmax_q;
        out_ymin_d  = out_ymin_q;
        out_ymax_d  = out_ymax_q;
`ifdef BBOX_AREA_EN
        out_area_d  = out_area_q;
`endif
        dropped_d   = dropped_q || (en && state_q != ST_ACCUM);
        we          = s1_valid_q;
        wa          = s1_label_q;
        wd          = merged;
        case (state_q)
            ST_CLEAR: begin
                we      = 1'b1;
                wa      = idx_q;
                wd      = '0;
                idx_d   = idx_q + LABEL_W'(1);
                state_d = &idx_q ? ST_ACCUM : ST_CLEAR;
            end
            ST_ACCUM: begin
                flush_cnt_d = 1'b0;
                state_d     = frame_end ? ST_FLUSH : ST_ACCUM;
            end
            ST_FLUSH: begin
                idx_d       = LABEL_W'(1);
                flush_cnt_d = 1'b1;
                state_d     = flush_cnt_q ? ST_DUMP : ST_FLUSH;
            end
            ST_DUMP: begin
                if (out_valid_q) begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        we          = 1'b1;
                        wa          = idx_q;
                        wd          = '0;
                        idx_d       = idx_q + LABEL_W'(1);
                        state_d     = &idx_q ? ST_DONE : ST_DUMP;
                    end
                end else if (rd_q[VB]) begin
                    out_valid_d = 1'b1;
                    out_label_d = idx_q;
                    out_xmin_d  = rd_q[F_XMIN*COORD_W +: COORD_W];
                    out_xmax_d  = rd_q[F_XMAX*COORD_W +: COORD_W];
                    out_ymin_d  = rd_q[F_YMIN*COORD_W +: COORD_W];
                    out_ymax_d  = rd_q[F_YMAX*COORD_W +: COORD_W];
`ifdef BBOX_AREA_EN
                    out_area_d  = rd_q[VB+1 +: 2*COORD_W];
`endif
                end else begin
                    idx_d   = idx_q + LABEL_W'(1);
                    state_d = &idx_q ? ST_DONE : ST_DUMP;
                end
            end
            ST_DONE:  state_d = ST_ACCUM;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            flush_cnt_q <= 1'b0;
            idx_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_label_q  <= '0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_label_q  <= '0;
            s2_entry_q  <= '0;
            out_valid_q <= 1'b0;
            out_label_q <= '0;
            out_xmin_q  <= '0;
            out_xmax_q  <= '0;
            out_ymin_q  <= '0;
            out_ymax_q  <= '0;
`ifdef BBOX_AREA_EN
            out_area_q  <= '0;
`endif
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            idx_q       <= idx_d;
            s1_valid_q  <= s1_valid_d;
            s1_label_q  <= s1_label_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s2_valid_q  <= s2_valid_d;
            s2_label_q  <= s2_label_d;
            s2_entry_q  <= s2_entry_d;
            out_valid_q <= out_valid_d;
            out_label_q <= out_label_d;
            out_xmin_q  <= out_xmin_d;
            out_xmax_q  <= out_xmax_d;
            out_ymin_q  <= out_ymin_d;
            out_ymax_q  <= out_ymax_d;
`ifdef BBOX_AREA_EN
            out_area_q  <= out_area_d;
`endif
            dropped_q   <= dropped_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd_q <= mem[rd_addr];
    end

    assign out_valid = out_valid_q;
    assign out_label = out_label_q;
    assign out_xmin  = out_xmin_q;
    assign out_xmax  = out_xmax_q;
    assign out_ymin  = out_ymin_q;
    assign out_ymax  = out_ymax_q;
    assign busy      = state_q != ST_ACCUM;
    assign dropped   = dropped_q;
endmodule

// File: tb/tb_blob_bbox_tracker.sv
// tb_blob_bbox_tracker: directed frames with a scoreboard of expected boxes.
module tb_blob_bbox_tracker;
    logic        clk = 1'b0;
    logic        reset, en, frame_end, out_ready;
    logic [31:0] x, y;
    logic [7:0]  label;
    logic        out_valid, busy, dropped;
    logic [7:0]  out_label;
    logic [10:0] out_xmin, out_xmax, out_ymin, out_ymax;
`ifdef BBOX_AREA_EN
    logic [21:0] out_area;
`endif
    int checks = 0;
    int failures = 0;
    logic [51:0] sb[$];

    always #5 clk = ~clk;

    blob_bbox_tracker dut (
        .clk(clk), .reset(reset), .en(en), .x(x), .y(y), .label(label),
        .frame_end(frame_end), .out_valid(out_valid), .out_ready(out_ready),
        .out_label(out_label), .out_xmin(out_xmin), .out_xmax(out_xmax),
        .out_ymin(out_ymin), .out_ymax(out_ymax),
`ifdef BBOX_AREA_EN
        .out_area(out_area),
`endif
        .busy(busy), .dropped(dropped)
    );

    function automatic logic [51:0] box(input int l, xa, xb, ya, yb);
        return {8'(l), 11'(xa), 11'(xb), 11'(ya), 11'(yb)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input int l, input int xx, input int yy, input bit fe);
        en = 1'b1; label = 8'(l); x = 32'(xx); y = 32'(yy); frame_end = fe;
        @(negedge clk);
        en = 1'b0; frame_end = 1'b0;
    endtask

    task automatic fend();
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic drain(input string tag, input int stall, input bit inject);
        int cyc = 0;
        int first = -1;
        bit seen = 1'b0;
        bit cap = 1'b0;
        logic [51:0] held = '0;
        logic [51:0] obs;
        out_ready = 1'b0;
        while (cyc < 2000) begin
            if (busy) seen = 1'b1;
            if (seen && !busy) break;
            out_ready = 1'b0;
            if (out_valid) begin
                obs = {out_label, out_xmin, out_xmax, out_ymin, out_ymax};
                if (first < 0) first = cyc;
                if (stall > 0) begin
                    if (cap) chk({tag, "_hold"}, obs, held);
                    held = obs;
                    cap = 1'b1;
                    stall--;
                    if (inject) begin
                        en = 1'b1; label = 8'd11; x = 32'd100; y = 32'd100;
                        inject = 1'b0;
                    end
                end else begin
                    checks++;
                    assert (sb.size() != 0) else begin
                        failures++;
                        $error("FAIL %s_extra observed_label=%0d expected=none", tag, out_label);
                    end
                    if (sb.size() != 0) chk({tag, "_box"}, obs, sb.pop_front());
                    out_ready = 1'b1;
                    cap = 1'b0;
                end
            end
            @(negedge clk);
            en = 1'b0;
            cyc++;
        end
        out_ready = 1'b0;
        chk({tag, "_ended"}, cyc < 2000, 1);
        chk({tag, "_left"}, sb.size(), 0);
        if (first >= 0) chk({tag, "_latency"}, first >= 2, 1);
        sb.delete();
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; frame_end = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; label = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", {out_label, out_xmin, out_xmax, out_ymin, out_ymax}, 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_busy", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("clear_busy", busy, 1);
        wait_idle("clear_done");

        pix(5, 10, 3, 0); pix(5, 2, 7, 0); pix(5, 15, 1, 0);
        sb.push_back(box(5, 2, 15, 1, 7));
        fend();
        drain("single", 0, 0);

        pix(9, 4, 0, 0); pix(9, 1, 0, 0); pix(9, 8, 0, 0); pix(9, 0, 0, 0);
        sb.push_back(box(9, 0, 8, 0, 0));
        fend();
        drain("fwd", 0, 0);

        pix(0, 1, 1, 0); pix(3, 5, 6, 0); pix(0, 2, 2, 0); pix(200, 7, 8, 0);
        sb.push_back(box(3, 5, 5, 6, 6));
        sb.push_back(box(200, 7, 7, 8, 8));
        fend();
        drain("order", 0, 0);

        pix(42, 1, 2, 0);
        sb.push_back(box(42, 1, 1, 2, 2));
        fend();
        drain("stall", 5, 0);
        fend();
        drain("empty", 0, 0);

        chk("dropped_before", dropped, 0);
        pix(11, 4, 4, 0);
        sb.push_back(box(11, 4, 4, 4, 4));
        fend();
        drain("drop", 3, 1);
        chk("dropped_after", dropped, 1);
        pix(7, 5, 9, 0);
        pix(7, 3, 3, 1);
        sb.push_back(box(7, 3, 5, 3, 9));
        drain("same_end", 0, 0);

        pix(20, 1, 1, 0);
        fend();
        begin
            int n = 0;
            while (!out_valid && n < 600) begin
                @(negedge clk);
                n++;
            end
        end
        chk("dump_reached", out_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 1);
        chk("midrst_dropped", dropped, 0);
        reset = 1'b0;
        wait_idle("midrst_clear");
        pix(30, 2, 2, 0);
        sb.push_back(box(30, 2, 2, 2, 2));
        fend();
        drain("after_rst", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
